dma_desc_queue: RTL and testbench

DMA_DESC_QUEUE -- requirements
Module: dma_desc_queue

---
 rtl/dma_desc_queue.sv | 177 +++++++++++++++++
 tb/tb_dma_desc_queue.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_desc_queue.sv
// Descriptor FIFO feeding a single-byte DMA engine through an IDLE/LOAD/ISSUE/WAIT sequencer.
// Optional build macro DMA_DESC_TIMEOUT_EN adds a WAIT watchdog and the err output.
module dma_desc_queue #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       desc_valid,
    output logic       desc_ready,
    input  logic [3:0] desc_src,
    input  logic [3:0] desc_dst,
    input  logic [3:0] desc_len,
    output logic       dma_start,
    output logic [3:0] dma_src_addr,
    output logic [3:0] dma_dst_addr,
    input  logic       dma_done,
    output logic       desc_done,
    output logic [3:0] fifo_level,
`ifdef DMA_DESC_TIMEOUT_EN
    output logic       err,
`endif
    output logic       busy
);

    localparam int         PTR_W    = $clog2(DEPTH);
    localparam logic [3:0] FULL_LVL = 4'(DEPTH);

    typedef struct packed {
        logic [3:0] src;
        logic [3:0] dst;
        logic [3:0] len;
    } desc_t;

    typedef enum logic [1:0] {IDLE, LOAD, ISSUE, WAIT} state_t;

    desc_t              mem_q [DEPTH];
    desc_t              head;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [3:0]         count_q, count_d;
    state_t             state_q, state_d;
    logic [3:0]         src_q, src_d;
    logic [3:0]         dst_q, dst_d;
    logic [4:0]         rem_q, rem_d;
    logic               dma_start_q, dma_start_d;
    logic               desc_done_q, desc_done_d;
    logic               push, pop;
`ifdef DMA_DESC_TIMEOUT_EN
    logic [3:0]         wd_q, wd_d;
    logic               err_q, err_d;
`endif

    // Ready comes from the registered level only, so a same-cycle pop never frees a slot early.
    assign desc_ready = (count_q != FULL_LVL);
    assign push       = desc_valid && desc_ready;
    assign pop        = (state_q == IDLE) && (count_q != 4'd0);
    assign head       = mem_q[rd_ptr_q];

    // NOTE: descriptor storage has no reset; the pointers and level alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{src: desc_src, dst: desc_dst, len: desc_len};
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case leaves it unassigned.
        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d     = count_q;
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        rem_d       = rem_q;
        dma_start_d = 1'b0;
        desc_done_d = 1'b0;
`ifdef DMA_DESC_TIMEOUT_EN
        wd_d        = wd_q;
        err_d       = 1'b0;
`endif
        case ({push, pop})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                if (pop) begin
                    src_d   = head.src;
                    dst_d   = head.dst;
                    rem_d   = {1'b0, head.len} + 5'd1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d     = ISSUE;
                dma_start_d = 1'b1;
            end
            ISSUE: begin
                // A done pulse here belongs to nothing in flight and is ignored.
                state_d = WAIT;
`ifdef DMA_DESC_TIMEOUT_EN
                wd_d    = 4'd0;
`endif
            end
            WAIT: begin
                if (dma_done) begin
                    if (rem_q == 5'd1) begin
                        desc_done_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        rem_d       = rem_q - 5'd1;
                        src_d       = src_q + 4'd1;
                        dst_d       = dst_q + 4'd1;
                        state_d     = ISSUE;
                        dma_start_d = 1'b1;
                    end
                end
`ifdef DMA_DESC_TIMEOUT_EN
                // wd_q == 14 means this is the 15th WAIT cycle without a completion.
                else if (wd_q == 4'd14) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + 4'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= 4'd0;
            state_q     <= IDLE;
            src_q       <= 4'd0;
            dst_q       <= 4'd0;
            rem_q       <= 5'd0;
            dma_start_q <= 1'b0;
            desc_done_q <= 1'b0;
`ifdef DMA_DESC_TIMEOUT_EN
            wd_q        <= 4'd0;
            err_q       <= 1'b0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            rem_q       <= rem_d;
            dma_start_q <= dma_start_d;
            desc_done_q <= desc_done_d;
`ifdef DMA_DESC_TIMEOUT_EN
            wd_q        <= wd_d;
            err_q       <= err_d;
`endif
        end
    end

    assign dma_start    = dma_start_q;
    assign dma_src_addr = src_q;
    assign dma_dst_addr = dst_q;
    assign desc_done    = desc_done_q;
    assign fifo_level   = count_q;
    assign busy         = (state_q != IDLE) || (count_q != 4'd0);
`ifdef DMA_DESC_TIMEOUT_EN
    assign err          = err_q;
`endif

endmodule

// File: tb/tb_dma_desc_queue.sv
// Self-checking bench for dma_desc_queue: directed scenarios plus a randomized run,
// compared against an expected byte stream expanded from each accepted descriptor.
module tb_dma_desc_queue;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       desc_valid = 1'b0;
    logic       desc_ready;
    logic [3:0] desc_src = 4'd0;
    logic [3:0] desc_dst = 4'd0;
    logic [3:0] desc_len = 4'd0;
    logic       dma_start;
    logic [3:0] dma_src_addr;
    logic [3:0] dma_dst_addr;
    logic       dma_done = 1'b0;
    logic       desc_done;
    logic [3:0] fifo_level;
    logic       busy;
`ifdef DMA_DESC_TIMEOUT_EN
    logic       err;
`endif

    dma_desc_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_src(desc_src), .desc_dst(desc_dst), .desc_len(desc_len),
        .dma_start(dma_start), .dma_src_addr(dma_src_addr), .dma_dst_addr(dma_dst_addr),
        .dma_done(dma_done), .desc_done(desc_done), .fifo_level(fifo_level),
`ifdef DMA_DESC_TIMEOUT_EN
        .err(err),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [3:0] src; logic [3:0] dst; logic [3:0] len; } desc_t;
    typedef struct { logic [3:0] s; logic [3:0] d; bit last; } byte_t;

    desc_t push_q[$];
    byte_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    countdown = -1;
    bit    cur_last = 1'b0;
    bit    expect_dd = 1'b0;
    bit    hold_engine = 1'b0;
    bit    spur_in_issue = 1'b0;
    bit    random_gaps = 1'b0;
    int    fixed_delay = 1;
    int    starts_seen = 0;
    int    dd_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic add_desc(input logic [3:0] s, input logic [3:0] d, input logic [3:0] l);
        desc_t x;
        x.src = s; x.dst = d; x.len = l;
        push_q.push_back(x);
    endtask

    // One clock of producer + engine model; called at the sample point 1 time unit after an edge.
    task automatic cycle();
        bit    acc;
        bit    dd_next;
        byte_t b;
        desc_t x;
        if (expect_dd) begin
            check("desc_done_pulse", desc_done, 1);
            if (desc_done) dd_seen++;
        end else begin
            check("desc_done_quiet", desc_done, 0);
        end
        dma_done = 1'b0;
        dd_next  = 1'b0;
        if (countdown == 0 && !hold_engine) begin
            dma_done  = 1'b1;
            dd_next   = cur_last;
            countdown = -1;
        end else if (countdown > 0) begin
            countdown--;
        end
        if (dma_start) begin
            starts_seen++;
            if (spur_in_issue) dma_done = 1'b1;
            if (exp_q.size() == 0) begin
                check("start_unexpected", dma_start, 0);
            end else begin
                b = exp_q.pop_front();
                check("byte_src", dma_src_addr, b.s);
                check("byte_dst", dma_dst_addr, b.d);
                cur_last  = b.last;
                countdown = (fixed_delay > 0) ? fixed_delay - 1 : int'($urandom_range(3, 0));
            end
        end
        desc_valid = 1'b0;
        if (push_q.size() != 0 && !(random_gaps && desc_ready && $urandom_range(3, 0) == 0)) begin
            desc_valid = 1'b1;
            desc_src   = push_q[0].src;
            desc_dst   = push_q[0].dst;
            desc_len   = push_q[0].len;
        end
        acc = desc_valid && desc_ready;
        @(posedge clk);
        #1;
        if (acc) begin
            x = push_q.pop_front();
            for (int i = 0; i <= int'(x.len); i++) begin
                b.s    = x.src + 4'(i);
                b.d    = x.dst + 4'(i);
                b.last = (i == int'(x.len));
                exp_q.push_back(b);
            end
        end
        expect_dd = dd_next;
    endtask

    task automatic run(input int budget);
        int n = 0;
        while ((push_q.size() != 0 || exp_q.size() != 0 || countdown >= 0 || expect_dd) && n < budget) begin
            cycle();
            n++;
        end
        check("drain_in_budget", n < budget, 1);
        for (int i = 0; i < 3; i++) cycle();
        dma_done   = 1'b0;
        desc_valid = 1'b0;
        check("idle_after_drain", busy, 0);
    endtask

    initial begin
        int s0;
        int d0;
        int n;

        // Reset values
        #12;
        check("rst_desc_ready", desc_ready, 1);
        check("rst_dma_start", dma_start, 0);
        check("rst_desc_done", desc_done, 0);
        check("rst_fifo_level", fifo_level, 0);
        check("rst_busy", busy, 0);
        check("rst_src", dma_src_addr, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single byte: start latency, addresses, one completion
        fixed_delay = 4;
        s0 = starts_seen; d0 = dd_seen;
        add_desc(4'd2, 4'd9, 4'd0);
        cycle();
        cycle();
        check("lat_load_no_start", dma_start, 0);
        check("lat_busy", busy, 1);
        cycle();
        check("lat_start", dma_start, 1);
        check("lat_src", dma_src_addr, 2);
        check("lat_dst", dma_dst_addr, 9);
        run(200);
        check("single_starts", starts_seen - s0, 1);
        check("single_done", dd_seen - d0, 1);

        // Address wrap 15 -> 0
        fixed_delay = 1;
        s0 = starts_seen; d0 = dd_seen;
        add_desc(4'd14, 4'd0, 4'd3);
        run(200);
        check("wrap_starts", starts_seen - s0, 4);
        check("wrap_done", dd_seen - d0, 1);

        // Fill while the engine is stalled, then hold a descriptor against a full FIFO
        hold_engine = 1'b1;
        fixed_delay = 2;
        s0 = starts_seen; d0 = dd_seen;
        for (int i = 0; i < 6; i++) add_desc(4'(i), 4'(i + 8), 4'(i % 3));
        for (int i = 0; i < 5; i++) cycle();
        check("full_level", fifo_level, 4);
        check("full_ready", desc_ready, 0);
        for (int i = 0; i < 3; i++) cycle();
        check("full_hold_level", fifo_level, 4);
        check("full_hold_pending", push_q.size(), 1);
        hold_engine = 1'b0;
        run(500);
        check("full_starts", starts_seen - s0, 1 + 2 + 3 + 1 + 2 + 3);
        check("full_done", dd_seen - d0, 6);

        // Spurious completion in IDLE
        dma_done = 1'b1;
        @(posedge clk);
        #1;
        dma_done = 1'b0;
        check("spur_idle_busy", busy, 0);
        check("spur_idle_start", dma_start, 0);
        @(posedge clk);
        #1;
        check("spur_idle_desc_done", desc_done, 0);

        // Spurious completion during every ISSUE cycle
        spur_in_issue = 1'b1;
        fixed_delay = 3;
        d0 = dd_seen;
        add_desc(4'd5, 4'd6, 4'd2);
        run(200);
        spur_in_issue = 1'b0;
        check("spur_issue_done", dd_seen - d0, 1);

        // Randomized traffic with random engine latency and producer gaps
        fixed_delay = 0;
        random_gaps = 1'b1;
        d0 = dd_seen;
        for (int i = 0; i < 30; i++) add_desc(4'($urandom), 4'($urandom), 4'($urandom));
        n = 0;
        while ((push_q.size() != 0 || exp_q.size() != 0 || countdown >= 0 || expect_dd) && n < 5000) begin
            cycle();
            if (n % 50 == 0) check("rand_level_bound", fifo_level <= 4'd4, 1);
            n++;
        end
        check("rand_drain_in_budget", n < 5000, 1);
        check("rand_done", dd_seen - d0, 30);
        random_gaps = 1'b0;
        for (int i = 0; i < 3; i++) cycle();

        // Reset during WAIT of byte 2 of a len=5 descriptor, another one queued
        fixed_delay = 20;
        s0 = starts_seen;
        add_desc(4'd3, 4'd7, 4'd5);
        add_desc(4'd1, 4'd1, 4'd0);
        n = 0;
        while (starts_seen < s0 + 2 && n < 200) begin
            cycle();
            n++;
        end
        check("rst_mid_reached", starts_seen - s0, 2);
        rst_n = 1'b0;
        #2;
        check("rst_mid_start", dma_start, 0);
        check("rst_mid_desc_done", desc_done, 0);
        check("rst_mid_level", fifo_level, 0);
        check("rst_mid_ready", desc_ready, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_src", dma_src_addr, 0);
        check("rst_mid_dst", dma_dst_addr, 0);
        exp_q.delete();
        push_q.delete();
        countdown = -1;
        expect_dd = 1'b0;
        dma_done  = 1'b0;
        rst_n = 1'b1;
        s0 = starts_seen;
        for (int i = 0; i < 20; i++) cycle();
        check("rst_mid_no_starts", starts_seen - s0, 0);
        check("rst_mid_idle", busy, 0);

`ifdef DMA_DESC_TIMEOUT_EN
        // Watchdog: withhold completion, expect err then the next descriptor to run
        hold_engine = 1'b1;
        fixed_delay = 1;
        s0 = starts_seen; d0 = dd_seen;
        add_desc(4'd4, 4'd4, 4'd0);
        add_desc(4'd10, 4'd11, 4'd0);
        n = 0;
        while (starts_seen == s0 && n < 50) begin
            cycle();
            n++;
        end
        desc_valid = 1'b0;
        for (int i = 0; i < 14; i++) begin
            check("wd_err_early", err, 0);
            @(posedge clk);
            #1;
        end
        check("wd_err_early", err, 0);
        @(posedge clk);
        #1;
        check("wd_err_pulse", err, 1);
        check("wd_no_desc_done", desc_done, 0);
        @(posedge clk);
        #1;
        check("wd_err_one_cycle", err, 0);
        check("wd_no_desc_done_late", desc_done, 0);
        countdown = -1;
        expect_dd = 1'b0;
        hold_engine = 1'b0;
        run(300);
        check("wd_next_done", dd_seen - d0, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
